// File: rtl/xorshift128_checker.sv
// -----------------------------------------------------------------------------
// xorshift128_checker
//
// Receive-side monitor for a Xorshift128 word stream. The first four accepted
// words seed the generator state (HUNT); afterwards every accepted word is
// compared against the locally predicted next value (LOCK). Mismatches are
// counted, flagged with a one-cycle pulse, and a run of LOSS_THRESHOLD
// consecutive misses drops back to HUNT.
//
// The state always advances with the predicted word, never the received one.
// A corrupted word therefore costs exactly one mismatch and does not poison
// the following predictions.
//
// An all-zero seed is a self-consistent lock (zeros predict zeros). It is
// accepted silently.
//
// Parameters:
//   LOSS_THRESHOLD  consecutive misses in LOCK that force HUNT (1..15)
//   ERRCNT_W        width of the saturating error counter      (2..32)
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   clear       synchronous clear to HUNT with zeroed counters; beats in_valid
//   in_valid    in_data is accepted this cycle (no backpressure)
//   in_data     received 32-bit word
//   locked      1 while in LOCK
//   err_pulse   registered one-cycle pulse per mismatch seen in LOCK
//   err_count   saturating count of mismatches since reset/clear
//   word_count  saturating count of words compared in LOCK since reset/clear
// -----------------------------------------------------------------------------
module xorshift128_checker #(
   parameter int LOSS_THRESHOLD = 4,
   parameter int ERRCNT_W       = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clear,
   input  logic                in_valid,
   input  logic [31:0]         in_data,
   output logic                locked,
   output logic                err_pulse,
   output logic [ERRCNT_W-1:0] err_count,
   output logic [31:0]         word_count
);

   // Reject illegal parameterisations at elaboration time.
   if (LOSS_THRESHOLD < 1 || LOSS_THRESHOLD > 15) begin : g_bad_threshold
      $error("xorshift128_checker: LOSS_THRESHOLD must be 1..15");
   end
   if (ERRCNT_W < 2 || ERRCNT_W > 32) begin : g_bad_errcnt_w
      $error("xorshift128_checker: ERRCNT_W must be 2..32");
   end

   localparam logic [0:0] ST_HUNT = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   localparam logic [3:0]          LOSS_THR = 4'(LOSS_THRESHOLD);
   localparam logic [ERRCNT_W-1:0] ERR_ONE  = {{(ERRCNT_W-1){1'b0}}, 1'b1};

   // Generator state, oldest word in r_x.
   logic [31:0]         r_x;
   logic [31:0]         r_y;
   logic [31:0]         r_z;
   logic [31:0]         r_w;
   logic [0:0]          r_state;
   logic [1:0]          r_fill;        // words loaded so far while hunting
   logic [3:0]          r_miss;        // consecutive misses while locked
   logic                r_err_pulse;
   logic [ERRCNT_W-1:0] r_err_count;
   logic [31:0]         r_word_count;

   logic [31:0] w_t;
   logic [31:0] w_pred;
   logic        w_match;
   logic [3:0]  w_miss_next;

   // Next Xorshift128 output from the current state (logical shifts).
   assign w_t         = r_x ^ (r_x << 11);
   assign w_pred      = r_w ^ (r_w >> 19) ^ w_t ^ (w_t >> 8);
   assign w_match     = (in_data == w_pred);
   assign w_miss_next = r_miss + 4'd1;

   // NOTE: every register, including the 128-bit generator state, is reset so
   // that a reset mid-stream leaves nothing behind from the old lock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_x          <= '0;
         r_y          <= '0;
         r_z          <= '0;
         r_w          <= '0;
         r_state      <= ST_HUNT;
         r_fill       <= '0;
         r_miss       <= '0;
         r_err_pulse  <= 1'b0;
         r_err_count  <= '0;
         r_word_count <= '0;
      end else if (clear) begin
         // The word presented alongside clear is deliberately dropped.
         r_x          <= '0;
         r_y          <= '0;
         r_z          <= '0;
         r_w          <= '0;
         r_state      <= ST_HUNT;
         r_fill       <= '0;
         r_miss       <= '0;
         r_err_pulse  <= 1'b0;
         r_err_count  <= '0;
         r_word_count <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every right-hand side
         // sees the pre-edge state and the x<=y<=z<=w shift is a true shift.
         r_err_pulse <= 1'b0;
         if (in_valid) begin
            r_x <= r_y;
            r_y <= r_z;
            r_z <= r_w;
            if (r_state == ST_HUNT) begin
               r_w <= in_data;
               if (r_fill == 2'd3) begin
                  r_fill  <= '0;
                  r_state <= ST_LOCK;
               end else begin
                  r_fill <= r_fill + 2'd1;
               end
            end else begin
               // Flywheel: advance with the prediction, not the received word.
               r_w <= w_pred;
               if (r_word_count != '1) begin
                  r_word_count <= r_word_count + 32'd1;
               end
               if (w_match) begin
                  r_miss <= '0;
               end else begin
                  r_err_pulse <= 1'b1;
                  if (r_err_count != '1) begin
                     r_err_count <= r_err_count + ERR_ONE;
                  end
                  if (w_miss_next == LOSS_THR) begin
                     r_state <= ST_HUNT;
                     r_miss  <= '0;
                     r_fill  <= '0;
                  end else begin
                     r_miss <= w_miss_next;
                  end
               end
            end
         end
      end
   end

   assign locked     = (r_state == ST_LOCK);
   assign err_pulse  = r_err_pulse;
   assign err_count  = r_err_count;
   assign word_count = r_word_count;

endmodule

// File: tb/tb_xorshift128_checker.sv
// -----------------------------------------------------------------------------
// tb_xorshift128_checker
//
// Drives two checkers from the same stimulus: one with default parameters and
// one with LOSS_THRESHOLD=15, ERRCNT_W=2 for saturation. A reference model per
// instance keeps the last four accepted words in a small array and computes
// the Xorshift128 prediction from them directly.
// -----------------------------------------------------------------------------
module tb_xorshift128_checker;

   logic        clk;
   logic        reset_n;
   logic        clear;
   logic        in_valid;
   logic [31:0] in_data;

   logic        locked_a;
   logic        err_pulse_a;
   logic [15:0] err_count_a;
   logic [31:0] word_count_a;

   logic        locked_b;
   logic        err_pulse_b;
   logic [1:0]  err_count_b;
   logic [31:0] word_count_b;

   int n_chk = 0;
   int n_err = 0;

   xorshift128_checker dut_a (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .locked     (locked_a),
      .err_pulse  (err_pulse_a),
      .err_count  (err_count_a),
      .word_count (word_count_a)
   );

   xorshift128_checker #(.LOSS_THRESHOLD(15), .ERRCNT_W(2)) dut_b (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .locked     (locked_b),
      .err_pulse  (err_pulse_b),
      .err_count  (err_count_b),
      .word_count (word_count_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- model
   int unsigned     m_hist  [2][4];   // [0] oldest .. [3] newest
   bit              m_locked[2];
   int              m_fill  [2];
   int              m_miss  [2];
   longint unsigned m_err   [2];
   longint unsigned m_words [2];
   bit              m_pulse [2];
   int              m_thr   [2] = '{4, 15};
   longint unsigned m_errmax[2] = '{64'd65535, 64'd3};

   function automatic int unsigned xs_next(int unsigned x, int unsigned w);
      int unsigned t;
      t = x ^ (x << 11);
      return w ^ (w >> 19) ^ t ^ (t >> 8);
   endfunction

   function automatic int unsigned pred(int k);
      return xs_next(m_hist[k][0], m_hist[k][3]);
   endfunction

   task automatic model_reset(int k);
      for (int i = 0; i < 4; i++) m_hist[k][i] = 0;
      m_locked[k] = 0;
      m_fill[k]   = 0;
      m_miss[k]   = 0;
      m_err[k]    = 0;
      m_words[k]  = 0;
      m_pulse[k]  = 0;
   endtask

   task automatic push(int k, int unsigned v);
      for (int i = 0; i < 3; i++) m_hist[k][i] = m_hist[k][i+1];
      m_hist[k][3] = v;
   endtask

   task automatic model_step(int k, bit v, bit c, int unsigned d);
      int unsigned p;
      if (c) begin
         model_reset(k);
      end else if (!v) begin
         m_pulse[k] = 0;
      end else if (!m_locked[k]) begin
         m_pulse[k] = 0;
         push(k, d);
         m_fill[k]++;
         if (m_fill[k] == 4) begin
            m_locked[k] = 1;
            m_fill[k]   = 0;
         end
      end else begin
         p = pred(k);
         push(k, p);
         if (m_words[k] < 64'hFFFF_FFFF) m_words[k]++;
         if (d == p) begin
            m_pulse[k] = 0;
            m_miss[k]  = 0;
         end else begin
            m_pulse[k] = 1;
            if (m_err[k] < m_errmax[k]) m_err[k]++;
            m_miss[k]++;
            if (m_miss[k] == m_thr[k]) begin
               m_locked[k] = 0;
               m_miss[k]   = 0;
               m_fill[k]   = 0;
            end
         end
      end
   endtask

   // ---------------------------------------------------------------- checks
   task automatic check(string name, longint unsigned act, longint unsigned exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_models();
      check("A.locked",     64'(locked_a),     64'(m_locked[0]));
      check("A.err_pulse",  64'(err_pulse_a),  64'(m_pulse[0]));
      check("A.err_count",  64'(err_count_a),  m_err[0]);
      check("A.word_count", 64'(word_count_a), m_words[0]);
      check("B.locked",     64'(locked_b),     64'(m_locked[1]));
      check("B.err_pulse",  64'(err_pulse_b),  64'(m_pulse[1]));
      check("B.err_count",  64'(err_count_b),  m_err[1]);
      check("B.word_count", 64'(word_count_b), m_words[1]);
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(bit v, bit c, int unsigned d);
      in_valid = v;
      clear    = c;
      in_data  = d;
      @(posedge clk);
      #1;
      model_step(0, v, c, d);
      model_step(1, v, c, d);
      check_models();
      @(negedge clk);
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      bit          v;
      bit          c;
      int unsigned d;
      bit          lk;
      bit          ep;
      int unsigned ec;
      int unsigned wc;
   } vec_t;

   localparam int NV = 23;
   vec_t tbl[NV];

   localparam int unsigned S0 = 32'd123456789;
   localparam int unsigned S1 = 32'd362436069;
   localparam int unsigned S2 = 32'd521288629;
   localparam int unsigned S3 = 32'd88675123;
   localparam int unsigned O0 = 32'd3701687786;
   localparam int unsigned O1 = 32'd458299110;

   task automatic row(int i, bit v, bit c, int unsigned d,
                      bit lk, bit ep, int unsigned ec, int unsigned wc);
      tbl[i].v  = v;
      tbl[i].c  = c;
      tbl[i].d  = d;
      tbl[i].lk = lk;
      tbl[i].ep = ep;
      tbl[i].ec = ec;
      tbl[i].wc = wc;
   endtask

   int pulses;

   initial begin
      // Lock and match.
      row( 0, 0, 1, 0,  0, 0, 0, 0);
      row( 1, 1, 0, S0, 0, 0, 0, 0);
      row( 2, 1, 0, S1, 0, 0, 0, 0);
      row( 3, 1, 0, S2, 0, 0, 0, 0);
      row( 4, 1, 0, S3, 1, 0, 0, 0);
      row( 5, 1, 0, O0, 1, 0, 0, 1);
      row( 6, 1, 0, O1, 1, 0, 0, 2);
      // Loss of lock after four consecutive bad words.
      row( 7, 1, 0, 0,  1, 1, 1, 3);
      row( 8, 1, 0, 0,  1, 1, 2, 4);
      row( 9, 1, 0, 0,  1, 1, 3, 5);
      row(10, 1, 0, 0,  0, 1, 4, 6);
      // Re-lock; counters retained.
      row(11, 1, 0, S0, 0, 0, 4, 6);
      row(12, 1, 0, S1, 0, 0, 4, 6);
      row(13, 1, 0, S2, 0, 0, 4, 6);
      row(14, 1, 0, S3, 1, 0, 4, 6);
      row(15, 1, 0, O0, 1, 0, 4, 7);
      // Clear together with valid: word dropped, four fresh words needed.
      row(16, 1, 1, O1, 0, 0, 0, 0);
      row(17, 1, 0, S0, 0, 0, 0, 0);
      row(18, 1, 0, S1, 0, 0, 0, 0);
      row(19, 1, 0, S2, 0, 0, 0, 0);
      row(20, 1, 0, S3, 1, 0, 0, 0);
      // Single corrupted word, flywheel recovers on the next one.
      row(21, 1, 0, O0 + 1, 1, 1, 1, 1);
      row(22, 1, 0, O1,     1, 0, 1, 2);

      reset_n  = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      model_reset(0);
      model_reset(1);
      repeat (2) @(negedge clk);
      check("reset A.locked",     64'(locked_a),     0);
      check("reset A.err_pulse",  64'(err_pulse_a),  0);
      check("reset A.err_count",  64'(err_count_a),  0);
      check("reset A.word_count", 64'(word_count_a), 0);
      check("reset B.err_count",  64'(err_count_b),  0);
      reset_n = 1'b1;
      @(negedge clk);

      // Table-driven directed sequence.
      for (int i = 0; i < NV; i++) begin
         step(tbl[i].v, tbl[i].c, tbl[i].d);
         check($sformatf("row%0d locked", i),     64'(locked_a),     64'(tbl[i].lk));
         check($sformatf("row%0d err_pulse", i),  64'(err_pulse_a),  64'(tbl[i].ep));
         check($sformatf("row%0d err_count", i),  64'(err_count_a),  64'(tbl[i].ec));
         check($sformatf("row%0d word_count", i), 64'(word_count_a), 64'(tbl[i].wc));
      end

      // Saturation on the narrow instance: six bad words, counter sticks at 3.
      step(0, 1, 0);
      step(1, 0, S0);
      step(1, 0, S1);
      step(1, 0, S2);
      step(1, 0, S3);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         step(1, 0, 0);
         if (err_pulse_b) pulses++;
      end
      check("sat B.err_count", 64'(err_count_b), 3);
      check("sat B.pulses",    64'(pulses),      6);
      check("sat B.locked",    64'(locked_b),    1);

      // Gaps between sequence words produce no mismatches.
      step(0, 1, 0);
      step(1, 0, S0);
      step(0, 0, 32'hDEAD_BEEF);
      step(1, 0, S1);
      step(1, 0, S2);
      step(0, 0, 0);
      step(0, 0, 0);
      step(1, 0, S3);
      step(0, 0, 32'h1234_5678);
      step(1, 0, O0);
      step(0, 0, 0);
      step(1, 0, O1);
      check("gap A.err_count",  64'(err_count_a),  0);
      check("gap A.word_count", 64'(word_count_a), 2);
      check("gap A.locked",     64'(locked_a),     1);

      // Asynchronous reset mid-LOCK, checked before the next rising edge.
      #2 reset_n = 1'b0;
      #1;
      check("areset A.locked",     64'(locked_a),     0);
      check("areset A.err_count",  64'(err_count_a),  0);
      check("areset A.word_count", 64'(word_count_a), 0);
      check("areset B.locked",     64'(locked_b),     0);
      model_reset(0);
      model_reset(1);
      @(negedge clk);
      reset_n = 1'b1;

      // Randomised traffic, mostly well-formed with injected errors and clears.
      for (int i = 0; i < 400; i++) begin
         bit          v;
         bit          c;
         int unsigned d;
         int unsigned sel;
         v   = ($urandom_range(0, 3) != 0);
         c   = ($urandom_range(0, 49) == 0);
         sel = $urandom_range(0, 5);
         if (sel == 0)                       d = $urandom;
         else if (sel == 1 && m_locked[1])   d = pred(1);
         else if (m_locked[0])               d = pred(0);
         else                                d = $urandom;
         step(v, c, d);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/xorshift128_checker.md
Name: xorshift128_checker

Overview:
- Receive-side counterpart of the Xorshift128 random generator used with NiosII.
- Accepts a stream of 32-bit words and self-synchronises to the Xorshift128 sequence: the first four accepted words are loaded as generator state.
- From then on it predicts each next word, compares it with the received word, and counts mismatches.
- Drops lock after a run of consecutive misses; used as a bench/BIST monitor on links or memories fed from the generator.

Parameters:
- LOSS_THRESHOLD, 4, number of consecutive mismatches in LOCK that forces a return to HUNT; legal range 1..15.
- ERRCNT_W, 16, width of the saturating error counter; legal range 2..32.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear: return to HUNT and zero all counters.
- in_valid  input  1  in_data is presented this cycle; no backpressure, a word is accepted on every cycle in_valid=1.
- in_data  input  32  received word.
- locked  output  1  1 while in LOCK.
- err_pulse  output  1  one-cycle pulse, registered, for each mismatch detected in LOCK.
- err_count  output  ERRCNT_W  total mismatches since reset/clear; saturates at all-ones.
- word_count  output  32  words compared in LOCK since reset/clear; saturates at 0xFFFFFFFF.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State registers x, y, z, w = 0; fill counter = 0; miss counter = 0.
  - Outputs: locked=0, err_pulse=0, err_count=0, word_count=0.
  - FSM in HUNT.
- Prediction (combinational from state):
  - t = x ^ (x << 11), logical shift, truncated to 32 bits.
  - r = w ^ (w >> 19) ^ t ^ (t >> 8), logical shifts.
- HUNT:
  - On in_valid: x<=y, y<=z, z<=w, w<=in_data; fill counter increments.
  - When the 4th word is accepted: go to LOCK; locked=1 from the next cycle; fill counter resets.
  - No comparisons, no err_pulse and no counter changes while in HUNT.
- LOCK:
  - On in_valid: x<=y, y<=z, z<=w, w<=r. The state always advances with the predicted value (flywheel), never with in_data.
  - word_count increments (saturating).
  - If in_data==r: miss counter <= 0.
  - If in_data!=r:
    - err_pulse=1 on the following cycle.
    - err_count increments (saturating).
    - miss counter increments.
    - If the incremented miss count equals LOSS_THRESHOLD: go to HUNT; locked=0 on the following cycle; fill counter=0; miss counter=0. err_count and word_count are retained.
- in_valid=0: no state change at all; err_pulse returns to 0.
- clear=1 has priority over in_valid:
  - The word presented that cycle is dropped.
  - Next state: HUNT, with x, y, z, w, all counters, locked and err_pulse = 0.
- Latency:
  - locked, err_pulse and both counters update on the clock edge that accepts the word.
  - They are visible one cycle after the accepting cycle.
- Back-to-back in_valid on every cycle is fully supported; throughput is one word per clock.
- The all-zero state is a legal lock: four zero words followed by zeros match indefinitely. The checker does not detect this case; it is documented, not flagged.
- Reset asserted mid-operation aborts immediately; there is no partial-state retention.

Test Plan:
- Lock and match:
  - Stimulus: reset, then words 123456789, 362436069, 521288629, 88675123, 3701687786, 458299110 on consecutive cycles.
  - Required: locked=1 the cycle after the 4th word; err_pulse never asserted; err_count=0; word_count=2.
- Single error, flywheel:
  - Stimulus: as above, but send 3701687787 in place of 3701687786.
  - Required: one err_pulse; err_count=1; locked stays 1; 458299110 then matches, with no second pulse.
- Loss of lock:
  - Stimulus: after lock, send 4 consecutive zero words with LOSS_THRESHOLD=4.
  - Required: 4 err_pulses; err_count=4; locked=0 the cycle after the 4th bad word.
  - Then: the next 4 words re-lock; err_count stays 4.
- Clear vs valid:
  - Stimulus: assert clear together with in_valid during LOCK.
  - Required: next cycle locked=0, err_count=0, word_count=0; the word is ignored; 4 fresh words are needed to re-lock.
- Saturation:
  - Stimulus: ERRCNT_W=2, LOSS_THRESHOLD=15; after lock, send 6 bad words.
  - Required: err_count sticks at 3; 6 err_pulses; locked remains 1.
- Gaps and reset:
  - Stimulus: insert in_valid=0 gaps between sequence words; then pulse reset_n low mid-LOCK.
  - Required: gaps produce no mismatches; the reset pulse clears all outputs asynchronously, without waiting for a clock edge.
